// File: rtl/downcount_mon_pkg.sv
// Shared types and default sizing for the down-counter monitor.
// Latency: none (types and constants only).
// Backpressure: none.
package downcount_mon_pkg;

  typedef enum logic [1:0] {
    PRIME  = 2'd0,
    EMPTY  = 2'd1,
    LOCKED = 2'd2
  } mon_state_t;

  localparam int DEF_WIDTH         = 8;
  localparam int DEF_STABLE_CYCLES = 2;
  localparam int DEF_WRAP_W        = 16;

endpackage

// File: rtl/downcount_sync.sv
// Two-flop synchroniser for a multi-bit bus, synchronous active-high reset.
// Latency: 2 cycles from d_i to q_o.
// Backpressure: none, samples every edge.
module downcount_sync
  import downcount_mon_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] s1_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q <= '0;
      q_o  <= '0;
    end else begin
      s1_q <= d_i;
      q_o  <= s1_q;
    end
  end

endmodule

// File: rtl/downcount_monitor.sv
// Synchronises and stability-filters a ripple down-counter bus; flags wraps and (with DOWNCOUNT_STEP_CHECK_EN) non-decrement steps.
// Latency: a held input value commits STABLE_CYCLES+1 edges after it is first sampled.
// Backpressure: none; at most one commit per STABLE_CYCLES cycles.
module downcount_monitor
  import downcount_mon_pkg::*;
#(
  parameter int WIDTH         = DEF_WIDTH,
  parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
  parameter int WRAP_W        = DEF_WRAP_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [WIDTH-1:0]  count_in,
  input  logic              clr,
  output logic [WIDTH-1:0]  count_q,
  output logic              upd,
  output logic              wrap,
  output logic [WRAP_W-1:0] wrap_cnt,
  output logic              step_err
);

  localparam int STAB_W = $clog2(STABLE_CYCLES + 1);
  localparam logic [STAB_W-1:0] STAB_MAX = STAB_W'(STABLE_CYCLES);
  localparam logic [STAB_W-1:0] STAB_HIT = STAB_W'(STABLE_CYCLES - 1);
  localparam logic [WIDTH-1:0]  ALL_ONES = '1;

  logic [WIDTH-1:0]  s2;
  mon_state_t        state_q, state_d;
  logic              prime_q, prime_d;
  logic [WIDTH-1:0]  cand_q, cand_d;
  logic [STAB_W-1:0] stab_q, stab_d;
  logic [WIDTH-1:0]  count_d;
  logic              upd_d, wrap_d;
  logic [WRAP_W-1:0] wrap_cnt_d;
  logic              commit, locked_commit;

  downcount_sync #(.WIDTH(WIDTH)) u_sync (
    .clk (clk),
    .rst (rst),
    .d_i (count_in),
    .q_o (s2)
  );

  always_comb begin
    state_d       = state_q;
    prime_d       = prime_q;
    cand_d        = cand_q;
    stab_d        = stab_q;
    count_d       = count_q;
    upd_d         = 1'b0;
    commit        = 1'b0;
    locked_commit = 1'b0;
    case (state_q)
      PRIME: begin
        // Let the synchroniser flush its reset zeros before filtering starts.
        cand_d  = s2;
        stab_d  = '0;
        prime_d = 1'b1;
        if (prime_q) state_d = EMPTY;
      end
      default: begin
        if (s2 != cand_q) begin
          cand_d = s2;
          stab_d = STAB_W'(1);
        end else begin
          if (stab_q != STAB_MAX) stab_d = stab_q + STAB_W'(1);
          commit = (stab_q == STAB_HIT) && ((state_q == EMPTY) || (cand_q != count_q));
        end
        if (commit) begin
          count_d       = cand_q;
          upd_d         = 1'b1;
          state_d       = LOCKED;
          locked_commit = (state_q == LOCKED);
        end
      end
    endcase

    wrap_d     = locked_commit && (count_q == '0) && (cand_q == ALL_ONES);
    wrap_cnt_d = wrap_cnt;
    if (clr) begin
      wrap_cnt_d = wrap_d ? WRAP_W'(1) : '0;
    end else if (wrap_d && (wrap_cnt != '1)) begin
      wrap_cnt_d = wrap_cnt + WRAP_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= PRIME;
      prime_q  <= 1'b0;
      cand_q   <= '0;
      stab_q   <= '0;
      count_q  <= '0;
      upd      <= 1'b0;
      wrap     <= 1'b0;
      wrap_cnt <= '0;
    end else begin
      state_q  <= state_d;
      prime_q  <= prime_d;
      cand_q   <= cand_d;
      stab_q   <= stab_d;
      count_q  <= count_d;
      upd      <= upd_d;
      wrap     <= wrap_d;
      wrap_cnt <= wrap_cnt_d;
    end
  end

`ifdef DOWNCOUNT_STEP_CHECK_EN
  logic step_bad;
  logic step_err_d;

  // A new error beats a simultaneous clear so no event is ever lost.
  assign step_bad   = locked_commit && (cand_q != (count_q - WIDTH'(1)));
  assign step_err_d = step_bad ? 1'b1 : (clr ? 1'b0 : step_err);

  always_ff @(posedge clk) begin
    if (rst) step_err <= 1'b0;
    else     step_err <= step_err_d;
  end
`else
  assign step_err = 1'b0;
`endif

endmodule

// File: tb/tb_downcount_monitor.sv
// Directed bench for downcount_monitor: main instance with defaults, second instance with a 2-bit wrap counter.
// Inputs change 1ns after a rising edge; outputs are sampled at the same point.
module tb_downcount_monitor;

`ifdef DOWNCOUNT_STEP_CHECK_EN
  localparam logic STEP_EN = 1'b1;
`else
  localparam logic STEP_EN = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic [7:0]  count_in;
  logic        clr;
  logic [7:0]  count_q;
  logic        upd;
  logic        wrap;
  logic [15:0] wrap_cnt;
  logic        step_err;

  logic [7:0]  count_in2;
  logic        clr2;
  logic [7:0]  count_q2;
  logic        upd2;
  logic        wrap2;
  logic [1:0]  wrap_cnt2;
  logic        step_err2;

  int n_chk = 0;
  int n_bad = 0;
  int upd_seen;
  int wrap_seen;
  int wrap_misplaced;
  logic saw_1f;

  downcount_monitor dut (
    .clk      (clk),
    .rst      (rst),
    .count_in (count_in),
    .clr      (clr),
    .count_q  (count_q),
    .upd      (upd),
    .wrap     (wrap),
    .wrap_cnt (wrap_cnt),
    .step_err (step_err)
  );

  downcount_monitor #(.WRAP_W(2)) dut_w2 (
    .clk      (clk),
    .rst      (rst),
    .count_in (count_in2),
    .clr      (clr2),
    .count_q  (count_q2),
    .upd      (upd2),
    .wrap     (wrap2),
    .wrap_cnt (wrap_cnt2),
    .step_err (step_err2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    upd_seen  += int'(upd);
    wrap_seen += int'(wrap);
    if (wrap && !(upd && count_q == 8'hFF)) wrap_misplaced++;
    if (count_q == 8'h1F) saw_1f = 1'b1;
  endtask

  task automatic hold(input logic [7:0] v, input int n);
    count_in = v;
    repeat (n) tick();
  endtask

  task automatic clear_counts();
    upd_seen       = 0;
    wrap_seen      = 0;
    wrap_misplaced = 0;
    saw_1f         = 1'b0;
  endtask

  task automatic hold2(input logic [7:0] v);
    count_in2 = v;
    repeat (4) tick();
  endtask

  initial begin
    rst       = 1'b1;
    clr       = 1'b0;
    count_in  = 8'h37;
    clr2      = 1'b0;
    count_in2 = 8'h00;
    clear_counts();

    // Reset state, then release with 0x37 held
    repeat (2) tick();
    chk("rst_count_q", 32'(count_q), 32'h0);
    chk("rst_upd", 32'(upd), 32'h0);
    chk("rst_wrap_cnt", 32'(wrap_cnt), 32'h0);
    rst = 1'b0;
    clear_counts();
    repeat (3) tick();
    chk("rel_no_early_upd", 32'(upd_seen), 32'h0);
    tick();
    chk("rel_upd_e3", 32'(upd), 32'h1);
    chk("rel_count_q", 32'(count_q), 32'h37);
    repeat (6) tick();
    chk("rel_one_upd", 32'(upd_seen), 32'h1);
    chk("rel_wrap", 32'(wrap_seen), 32'h0);
    chk("rel_step_err", 32'(step_err), 32'h0);

    // Decrement through wrap; clear the 0x37->0x03 jump first
    clear_counts();
    hold(8'h03, 5);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    hold(8'h02, 6);
    hold(8'h01, 6);
    hold(8'h00, 6);
    hold(8'hFF, 6);
    chk("dec_upd_count", 32'(upd_seen), 32'h5);
    chk("dec_wrap_count", 32'(wrap_seen), 32'h1);
    chk("dec_wrap_with_ff", 32'(wrap_misplaced), 32'h0);
    chk("dec_wrap_cnt", 32'(wrap_cnt), 32'h1);
    chk("dec_step_err", 32'(step_err), 32'h0);
    chk("dec_count_q", 32'(count_q), 32'hFF);

    // Glitch rejection from 0x10
    hold(8'h10, 5);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    clear_counts();
    hold(8'h1F, 1);
    hold(8'h0F, 6);
    chk("glt_never_1f", 32'(saw_1f), 32'h0);
    chk("glt_one_upd", 32'(upd_seen), 32'h1);
    chk("glt_count_q", 32'(count_q), 32'h0F);
    chk("glt_step_err", 32'(step_err), 32'h0);

    // Step error from 0x20 to 0x80
    hold(8'h20, 5);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("stp_cleared", 32'(step_err), 32'h0);
    hold(8'h80, 6);
    chk("stp_count_q", 32'(count_q), 32'h80);
    chk("stp_set", 32'(step_err), 32'(STEP_EN));
    hold(8'h80, 6);
    chk("stp_sticky", 32'(step_err), 32'(STEP_EN));
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("stp_clr", 32'(step_err), 32'h0);
    // Clear landing on the same edge as a fresh error loses to the error
    count_in = 8'h10;
    repeat (3) tick();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("stp_clr_race_upd", 32'(upd), 32'h1);
    chk("stp_clr_race_err", 32'(step_err), 32'(STEP_EN));

    // Wrap saturation on the 2-bit counter instance
    clr2 = 1'b1;
    tick();
    clr2 = 1'b0;
    chk("sat_start", 32'(wrap_cnt2), 32'h0);
    for (int i = 0; i < 4; i++) begin
      hold2(8'hFF);
      hold2(8'h00);
    end
    chk("sat_wrap_cnt", 32'(wrap_cnt2), 32'h3);
    count_in2 = 8'hFF;
    repeat (3) tick();
    clr2 = 1'b1;
    tick();
    clr2 = 1'b0;
    chk("sat_clr_wrap_pulse", 32'(wrap2), 32'h1);
    chk("sat_clr_wrap_cnt", 32'(wrap_cnt2), 32'h1);

    // Reset mid-run while locked at 0x55
    hold(8'h55, 6);
    chk("mid_locked", 32'(count_q), 32'h55);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_count_q", 32'(count_q), 32'h0);
    chk("mid_upd", 32'(upd), 32'h0);
    chk("mid_wrap", 32'(wrap), 32'h0);
    chk("mid_wrap_cnt", 32'(wrap_cnt), 32'h0);
    chk("mid_step_err", 32'(step_err), 32'h0);
    clear_counts();
    repeat (3) tick();
    chk("mid_no_early_upd", 32'(upd_seen), 32'h0);
    tick();
    chk("mid_upd_e3", 32'(upd), 32'h1);
    chk("mid_recommit", 32'(count_q), 32'h55);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
